// File: rtl/fpdiv_prenorm.sv
// Operand pre-normalization for the fpdiv mantissa divider: classifies two
// single-precision operands and left-normalizes subnormal mantissas one bit per clock.
module fpdiv_prenorm (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        START,
   input  logic [31:0] InputA,
   input  logic [31:0] InputB,
   output logic        BUSY,
   output logic        DONE,
   output logic        SIGN,
   output logic [23:0] MANTA,
   output logic [23:0] MANTB,
   output logic [9:0]  EXPA,
   output logic [9:0]  EXPB,
   output logic [1:0]  CLASSA,
   output logic [1:0]  CLASSB
);

   localparam logic [1:0] CLS_ZERO   = 2'b00;
   localparam logic [1:0] CLS_FINITE = 2'b01;
   localparam logic [1:0] CLS_INF    = 2'b10;
   localparam logic [1:0] CLS_NAN    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t      state_reg;
   state_t      state_next;
   logic        load;
   logic        sign_reg;
   logic [1:0]  settled;

   logic [31:0] op       [2];
   logic [23:0] mant_reg [2];
   logic [9:0]  exp_reg  [2];
   logic [1:0]  cls_reg  [2];
   logic [23:0] mant_load[2];
   logic [9:0]  exp_load [2];
   logic [1:0]  cls_load [2];

   // Load-time decode of both operands; subnormals start at exponent -126.
   always_comb begin
      op[0] = InputA;
      op[1] = InputB;
      for (int i = 0; i < 2; i++) begin
         mant_load[i] = '0;
         exp_load[i]  = '0;
         cls_load[i]  = CLS_ZERO;
         if (op[i][30:23] == 8'd0) begin
            if (op[i][22:0] != 23'd0) begin
               cls_load[i]  = CLS_FINITE;
               mant_load[i] = {1'b0, op[i][22:0]};
               exp_load[i]  = 10'h382;
            end
         end else if (op[i][30:23] == 8'hFF) begin
            if (op[i][22:0] == 23'd0) begin
               cls_load[i] = CLS_INF;
            end else begin
               cls_load[i]  = CLS_NAN;
               mant_load[i] = {1'b0, op[i][22:0]};
            end
         end else begin
            cls_load[i]  = CLS_FINITE;
            mant_load[i] = {1'b1, op[i][22:0]};
            exp_load[i]  = {2'b00, op[i][30:23]} - 10'd127;
         end
      end
   end

   // Only finite operands with a hidden zero still need shifting.
   always_comb begin
      settled = '0;
      for (int i = 0; i < 2; i++) begin
         settled[i] = mant_reg[i][23] | (cls_reg[i] != CLS_FINITE);
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               load       = 1'b1;
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (&settled) begin
               state_next = ST_DONE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         sign_reg <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            mant_reg[i] <= '0;
            exp_reg[i]  <= '0;
            cls_reg[i]  <= CLS_ZERO;
         end
      end else if (load) begin
         sign_reg <= InputA[31] ^ InputB[31];
         for (int i = 0; i < 2; i++) begin
            mant_reg[i] <= mant_load[i];
            exp_reg[i]  <= exp_load[i];
            cls_reg[i]  <= cls_load[i];
         end
      end else if (state_reg == ST_SHIFT) begin
         for (int i = 0; i < 2; i++) begin
            if (!settled[i]) begin
               mant_reg[i] <= {mant_reg[i][22:0], 1'b0};
               exp_reg[i]  <= exp_reg[i] - 10'd1;
            end
         end
      end
   end

   assign BUSY   = (state_reg == ST_SHIFT);
   assign DONE   = (state_reg == ST_DONE);
   assign SIGN   = sign_reg;
   assign MANTA  = mant_reg[0];
   assign MANTB  = mant_reg[1];
   assign EXPA   = exp_reg[0];
   assign EXPB   = exp_reg[1];
   assign CLASSA = cls_reg[0];
   assign CLASSB = cls_reg[1];

endmodule

// File: tb/tb_fpdiv_prenorm.sv
// Directed self-checking bench for fpdiv_prenorm: one task per scenario,
// expected values hand-computed from IEEE-754 bit patterns.
module tb_fpdiv_prenorm;

   logic        CLOCK;
   logic        RESET;
   logic        START;
   logic [31:0] InputA;
   logic [31:0] InputB;
   logic        BUSY;
   logic        DONE;
   logic        SIGN;
   logic [23:0] MANTA;
   logic [23:0] MANTB;
   logic [9:0]  EXPA;
   logic [9:0]  EXPB;
   logic [1:0]  CLASSA;
   logic [1:0]  CLASSB;

   int tests_run = 0;
   int tests_failed = 0;

   fpdiv_prenorm dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .START (START),
      .InputA(InputA),
      .InputB(InputB),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .SIGN  (SIGN),
      .MANTA (MANTA),
      .MANTB (MANTB),
      .EXPA  (EXPA),
      .EXPB  (EXPB),
      .CLASSA(CLASSA),
      .CLASSB(CLASSB)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   // Presents operands with START for exactly one rising edge (edge k).
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      @(negedge CLOCK);
      InputA = a;
      InputB = b;
      START  = 1'b1;
      @(posedge CLOCK);
      #1;
      START  = 1'b0;
   endtask

   // Returns the number of edges after the current one until DONE is seen (bounded).
   task automatic wait_done(output int n);
      n = 0;
      while (n < 40 && DONE !== 1'b1) begin
         @(posedge CLOCK);
         #1;
         n++;
      end
   endtask

   task automatic test_reset;
      RESET  = 1'b0;
      START  = 1'b0;
      InputA = '0;
      InputB = '0;
      #12;
      tests_run++;
      if ({BUSY, DONE, SIGN, MANTA, MANTB, EXPA, EXPB, CLASSA, CLASSB} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got busy=%b done=%b manta=%h mantb=%h expa=%h expb=%h, want all 0",
                  BUSY, DONE, MANTA, MANTB, EXPA, EXPB);
      end
      @(negedge CLOCK);
      RESET = 1'b1;
      $display("[TB] reset released");
   endtask

   task automatic test_normal;
      int n;
      start_op(32'h3FBC0000, 32'h3FA00000);
      tests_run++;
      if (BUSY !== 1'b1 || DONE !== 1'b0) begin
         tests_failed++;
         $display("FAIL normal_busy: got busy=%b done=%b, want busy=1 done=0", BUSY, DONE);
      end
      wait_done(n);
      $display("[TB] normal A=3FBC0000 B=3FA00000 edges=%0d", n);
      tests_run++;
      if (n !== 1 || DONE !== 1'b1) begin
         tests_failed++;
         $display("FAIL normal_latency: got %0d edges done=%b, want 1 edge", n, DONE);
      end
      tests_run++;
      if (MANTA !== 24'hBC0000 || EXPA !== 10'h000 || CLASSA !== 2'b01) begin
         tests_failed++;
         $display("FAIL normal_a: got mant=%h exp=%h cls=%b, want BC0000 000 01", MANTA, EXPA, CLASSA);
      end
      tests_run++;
      if (MANTB !== 24'hA00000 || EXPB !== 10'h000 || CLASSB !== 2'b01 || SIGN !== 1'b0) begin
         tests_failed++;
         $display("FAIL normal_b: got mant=%h exp=%h cls=%b sign=%b, want A00000 000 01 0",
                  MANTB, EXPB, CLASSB, SIGN);
      end
      // Outputs must hold while DONE with no START.
      repeat (3) @(posedge CLOCK);
      #1;
      tests_run++;
      if (DONE !== 1'b1 || MANTA !== 24'hBC0000 || MANTB !== 24'hA00000) begin
         tests_failed++;
         $display("FAIL done_hold: got done=%b manta=%h mantb=%h, want 1 BC0000 A00000", DONE, MANTA, MANTB);
      end
   endtask

   task automatic test_subnormal;
      int n;
      start_op(32'h00195400, 32'hC0000000);
      wait_done(n);
      $display("[TB] subnormal A=00195400 B=C0000000 edges=%0d", n);
      tests_run++;
      if (n !== 4) begin
         tests_failed++;
         $display("FAIL sub_latency: got %0d edges, want 4", n);
      end
      tests_run++;
      if (MANTA !== 24'hCAA000 || EXPA !== 10'h37F || CLASSA !== 2'b01) begin
         tests_failed++;
         $display("FAIL sub_a: got mant=%h exp=%h cls=%b, want CAA000 37F 01", MANTA, EXPA, CLASSA);
      end
      tests_run++;
      if (MANTB !== 24'h800000 || EXPB !== 10'h001 || SIGN !== 1'b1) begin
         tests_failed++;
         $display("FAIL sub_b: got mant=%h exp=%h sign=%b, want 800000 001 1", MANTB, EXPB, SIGN);
      end
   endtask

   task automatic test_worst_case;
      int n;
      int busy_cnt;
      start_op(32'h00000001, 32'h00000001);
      n = 0;
      busy_cnt = 0;
      while (n < 40 && DONE !== 1'b1) begin
         if (BUSY === 1'b1) busy_cnt++;
         @(posedge CLOCK);
         #1;
         n++;
      end
      $display("[TB] worst A=00000001 B=00000001 edges=%0d busy=%0d", n, busy_cnt);
      tests_run++;
      if (n !== 24 || busy_cnt !== 24) begin
         tests_failed++;
         $display("FAIL worst_latency: got %0d edges busy %0d cycles, want 24 and 24", n, busy_cnt);
      end
      tests_run++;
      if (MANTA !== 24'h800000 || MANTB !== 24'h800000 || EXPA !== 10'h36B || EXPB !== 10'h36B) begin
         tests_failed++;
         $display("FAIL worst_result: got manta=%h mantb=%h expa=%h expb=%h, want 800000 800000 36B 36B",
                  MANTA, MANTB, EXPA, EXPB);
      end
   endtask

   task automatic test_specials;
      int n;
      start_op(32'h7F800000, 32'h00000000);
      wait_done(n);
      $display("[TB] special A=7F800000 B=00000000 edges=%0d", n);
      tests_run++;
      if (n !== 1) begin
         tests_failed++;
         $display("FAIL inf_zero_latency: got %0d edges, want 1", n);
      end
      tests_run++;
      if (CLASSA !== 2'b10 || CLASSB !== 2'b00 || MANTA !== 24'h0 || MANTB !== 24'h0 ||
          EXPA !== 10'h0 || EXPB !== 10'h0) begin
         tests_failed++;
         $display("FAIL inf_zero: got cls=%b/%b mant=%h/%h exp=%h/%h, want 10/00 0/0 0/0",
                  CLASSA, CLASSB, MANTA, MANTB, EXPA, EXPB);
      end
      start_op(32'h7FC00000, 32'h3F800000);
      wait_done(n);
      $display("[TB] special A=7FC00000 B=3F800000 edges=%0d", n);
      tests_run++;
      if (n !== 1 || CLASSA !== 2'b11 || MANTA !== 24'h400000 || EXPA !== 10'h0) begin
         tests_failed++;
         $display("FAIL nan: got edges=%0d cls=%b mant=%h exp=%h, want 1 11 400000 000", n, CLASSA, MANTA, EXPA);
      end
      tests_run++;
      if (CLASSB !== 2'b01 || MANTB !== 24'h800000 || EXPB !== 10'h0) begin
         tests_failed++;
         $display("FAIL nan_partner: got cls=%b mant=%h exp=%h, want 01 800000 000", CLASSB, MANTB, EXPB);
      end
   endtask

   task automatic test_start_in_shift;
      int n;
      start_op(32'h00000001, 32'h00000001);
      repeat (3) @(posedge CLOCK);
      start_op(32'h3F800000, 32'h3F800000);
      wait_done(n);
      $display("[TB] start-in-shift ignored edges=%0d", n);
      tests_run++;
      if (n !== 20) begin
         tests_failed++;
         $display("FAIL shift_start_latency: got %0d edges after second pulse, want 20", n);
      end
      tests_run++;
      if (MANTA !== 24'h800000 || EXPA !== 10'h36B || EXPB !== 10'h36B) begin
         tests_failed++;
         $display("FAIL shift_start_result: got manta=%h expa=%h expb=%h, want 800000 36B 36B",
                  MANTA, EXPA, EXPB);
      end
   endtask

   task automatic test_reset_mid_shift;
      int n;
      start_op(32'h00000001, 32'h00195400);
      repeat (5) @(posedge CLOCK);
      #3;
      RESET = 1'b0;
      #1;
      $display("[TB] reset asserted mid-shift");
      tests_run++;
      if ({BUSY, DONE, SIGN, MANTA, MANTB, EXPA, EXPB, CLASSA, CLASSB} !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid_shift: got busy=%b manta=%h mantb=%h expa=%h cls=%b, want all 0",
                  BUSY, MANTA, MANTB, EXPA, CLASSA);
      end
      @(negedge CLOCK);
      RESET = 1'b1;
      wait_done(n);
      tests_run++;
      if (DONE !== 1'b0 || BUSY !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_no_done: got done=%b busy=%b, want 0 0", DONE, BUSY);
      end
   endtask

   task automatic test_back_to_back;
      int n;
      start_op(32'h3FBC0000, 32'h3FA00000);
      wait_done(n);
      @(negedge CLOCK);
      InputA = 32'h00195400;
      InputB = 32'hC0000000;
      START  = 1'b1;
      @(posedge CLOCK);
      #1;
      START = 1'b0;
      tests_run++;
      if (DONE !== 1'b0 || BUSY !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_drop: got done=%b busy=%b, want 0 1", DONE, BUSY);
      end
      wait_done(n);
      $display("[TB] back-to-back A=00195400 B=C0000000 edges=%0d", n);
      tests_run++;
      if (n !== 4 || MANTA !== 24'hCAA000 || EXPA !== 10'h37F || SIGN !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_result: got edges=%0d mant=%h exp=%h sign=%b, want 4 CAA000 37F 1",
                  n, MANTA, EXPA, SIGN);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_subnormal();
      test_worst_case();
      test_specials();
      test_start_in_shift();
      test_reset_mid_shift();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
